ysyx_23060096_ifu: RTL and testbench

//  Instruction fetch unit feeding decode/execute of the NPC core. Owns the PC register,

---
 rtl/ysyx_23060096_ifu.sv | 130 +++++++++++++
 tb/tb_ysyx_23060096_ifu.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060096_ifu.sv
// Instruction fetch unit: owns the PC, fetches over req/gnt/rvalid,
// buffers one instruction toward decode, honours redirects and halt.
module ysyx_23060096_ifu #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            inst_valid,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc,
   input  logic            inst_ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            halt
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD,
      HALT
   } state_t;

   state_t          state;
   state_t          state_n;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_n;
   logic [XLEN-1:0] inst_n;
   logic [XLEN-1:0] inst_pc_n;
   logic            inst_valid_n;
   logic            drop;
   logic            drop_n;
   logic            halted;
   logic            halted_n;
   logic            hlt;
   logic [XLEN-1:0] target;

   assign hlt       = halted | halt;
   assign target    = redirect_pc & ~XLEN'(3);
   assign imem_req  = (state == REQ);
   assign imem_addr = pc;

   always_comb begin
      state_n      = state;
      pc_n         = pc;
      inst_n       = inst;
      inst_pc_n    = inst_pc;
      inst_valid_n = inst_valid;
      drop_n       = drop;
      halted_n     = hlt;
      case (state)
         IDLE: begin
            if (redirect_valid) pc_n = target;
            state_n = hlt ? HALT : REQ;
         end
         REQ: begin
            if (redirect_valid) pc_n = target;
            // a granted request must complete, even when halting
            if (imem_gnt) begin
               state_n = WAIT;
               drop_n  = redirect_valid;
            end else if (hlt) begin
               state_n = HALT;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               if (redirect_valid || drop) begin
                  if (redirect_valid) pc_n = target;
                  drop_n  = 1'b0;
                  state_n = hlt ? HALT : REQ;
               end else begin
                  inst_n       = imem_rdata;
                  inst_pc_n    = pc;
                  inst_valid_n = 1'b1;
                  state_n      = HOLD;
               end
            end else if (redirect_valid) begin
               pc_n   = target;
               drop_n = 1'b1;
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               pc_n         = target;
               inst_valid_n = 1'b0;
               state_n      = hlt ? HALT : REQ;
            end else if (inst_ready) begin
               pc_n         = pc + XLEN'(4);
               inst_valid_n = 1'b0;
               state_n      = hlt ? HALT : REQ;
            end
         end
         HALT: begin
            inst_valid_n = 1'b0;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         inst       <= '0;
         inst_pc    <= '0;
         inst_valid <= 1'b0;
         drop       <= 1'b0;
         halted     <= 1'b0;
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         inst       <= inst_n;
         inst_pc    <= inst_pc_n;
         inst_valid <= inst_valid_n;
         drop       <= drop_n;
         halted     <= halted_n;
      end
   end

endmodule

// File: tb/tb_ysyx_23060096_ifu.sv
// Bench for ysyx_23060096_ifu: transaction-level model, random memory
// and decode stimulus, plus directed scenarios with literal values.
module tb_ysyx_23060096_ifu;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;

   ysyx_23060096_ifu #(
      .XLEN     (32),
      .RESET_PC (32'h8000_0000)
   ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;
   bit rnd    = 1'b0;
   int gnt_pct, rdy_pct, redir_pct, halt_pm;

   // model: fetch bookkeeping in transaction terms
   bit          m_started = 1'b0;
   bit          m_halted  = 1'b0;
   bit          m_out     = 1'b0;
   bit          m_drop    = 1'b0;
   bit          m_bv      = 1'b0;
   logic [31:0] m_pc      = 32'h8000_0000;
   logic [31:0] m_inst    = '0;
   logic [31:0] m_ipc     = '0;

   // memory responder state
   bit          s_req     = 1'b0;
   bit          mem_pend  = 1'b0;
   bit          mem_late  = 1'b0;
   int          mem_cnt   = 0;
   logic [31:0] mem_data  = '0;
   int          lat_cfg   = 0;
   bit          fix_en    = 1'b0;
   logic [31:0] fix_data  = '0;

   function automatic bit m_req();
      return m_started && !m_halted && !m_out && !m_bv;
   endfunction

   always @(posedge clk) begin
      bit fire, resp, bv0, stopped;
      if (rst) begin
         m_started = 1'b0;
         m_halted  = 1'b0;
         m_out     = 1'b0;
         m_drop    = 1'b0;
         m_bv      = 1'b0;
         m_pc      = 32'h8000_0000;
         m_inst    = '0;
         m_ipc     = '0;
      end else begin
         fire    = m_req() && imem_gnt;
         resp    = m_out && imem_rvalid;
         bv0     = m_bv;
         stopped = m_started && m_halted && !m_out && !m_bv;
         if (!m_started) begin
            m_started = 1'b1;
            if (redirect_valid) m_pc = redirect_pc & ~32'd3;
         end else if (stopped) begin
            m_started = 1'b1;
         end else if (redirect_valid) begin
            m_pc = redirect_pc & ~32'd3;
            m_bv = 1'b0;
            if (fire) begin
               m_out  = 1'b1;
               m_drop = 1'b1;
            end else if (resp) begin
               m_out  = 1'b0;
               m_drop = 1'b0;
            end else if (m_out) begin
               m_drop = 1'b1;
            end
         end else begin
            if (fire) m_out = 1'b1;
            if (resp) begin
               m_out = 1'b0;
               if (m_drop) begin
                  m_drop = 1'b0;
               end else begin
                  m_bv   = 1'b1;
                  m_inst = imem_rdata;
                  m_ipc  = m_pc;
               end
            end
            if (bv0 && inst_ready) begin
               m_bv = 1'b0;
               m_pc = m_pc + 32'd4;
            end
         end
         m_halted = m_halted | halt;
      end
      if (rst) begin
         if (mem_pend) mem_late = 1'b1;
         mem_pend = 1'b0;
      end else begin
         if (imem_rvalid) begin
            if (mem_late) mem_late = 1'b0;
            else mem_pend = 1'b0;
         end else if (mem_pend && mem_cnt > 0) begin
            mem_cnt--;
         end
         if (s_req && imem_gnt) begin
            mem_pend = 1'b1;
            mem_cnt  = rnd ? int'($urandom_range(0, 3)) : lat_cfg;
            mem_data = fix_en ? fix_data : $urandom;
         end
      end
   end

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic timeout(string name, int maxc);
      n_chk++;
      n_fail++;
      $display("FAIL %s: no event within %0d cycles at %0t", name, maxc, $time);
   endtask

   task automatic compare();
      chk("imem_req", {31'd0, imem_req}, {31'd0, m_req()});
      chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_bv});
      if (m_req()) chk("imem_addr", imem_addr, m_pc);
      if (m_bv) begin
         chk("inst", inst, m_inst);
         chk("inst_pc", inst_pc, m_ipc);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      if (chk_en) compare();
      s_req       = imem_req;
      imem_rvalid = (mem_pend && mem_cnt == 0) || (mem_late && !rst);
      imem_rdata  = imem_rvalid ? mem_data : $urandom;
      if (rnd) begin
         rst            = ($urandom_range(0, 399) == 0);
         imem_gnt       = ($urandom_range(0, 99) < gnt_pct);
         inst_ready     = ($urandom_range(0, 99) < rdy_pct);
         redirect_valid = ($urandom_range(0, 99) < redir_pct);
         redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
         halt           = ($urandom_range(0, 999) < halt_pm);
      end
   endtask

   task automatic wait_valid(string name, int maxc);
      int k = 0;
      while (!inst_valid && k < maxc) begin
         cyc();
         k++;
      end
      if (!inst_valid) timeout(name, maxc);
   endtask

   initial begin
      int k;
      rst            = 1'b1;
      imem_gnt       = 1'b0;
      imem_rvalid    = 1'b0;
      imem_rdata     = '0;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      halt           = 1'b0;

      cyc();
      chk_en = 1'b1;
      cyc();
      cyc();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, 32'h8000_0000);
      chk("rst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_inst_pc", inst_pc, 32'd0);

      imem_gnt   = 1'b1;
      rst        = 1'b0;
      fix_en     = 1'b1;
      fix_data   = 32'h0010_0093;
      inst_ready = 1'b1;
      cyc();
      chk("first_req", {31'd0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'h8000_0000);
      cyc();
      chk("wait_req", {31'd0, imem_req}, 32'd0);
      cyc();
      chk("lat_valid", {31'd0, inst_valid}, 32'd1);
      chk("lat_inst", inst, 32'h0010_0093);
      chk("lat_pc", inst_pc, 32'h8000_0000);
      fix_data = 32'h0020_0113;
      cyc();
      chk("next_req", {31'd0, imem_req}, 32'd1);
      chk("next_addr", imem_addr, 32'h8000_0004);

      inst_ready = 1'b0;
      cyc();
      cyc();
      for (int i = 0; i < 6; i++) begin
         chk("hold_valid", {31'd0, inst_valid}, 32'd1);
         chk("hold_inst", inst, 32'h0020_0113);
         chk("hold_pc", inst_pc, 32'h8000_0004);
         chk("hold_req", {31'd0, imem_req}, 32'd0);
         if (i < 5) cyc();
      end
      inst_ready = 1'b1;
      fix_en     = 1'b0;
      lat_cfg    = 2;
      cyc();
      chk("seq_addr", imem_addr, 32'h8000_0008);

      cyc();
      chk("redir_wait", {31'd0, imem_req}, 32'd0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0102;
      cyc();
      redirect_valid = 1'b0;
      k = 0;
      while (!imem_req && k < 10) begin
         chk("drop_valid", {31'd0, inst_valid}, 32'd0);
         cyc();
         k++;
      end
      if (imem_req) chk("redir_addr", imem_addr, 32'h8000_0100);
      else timeout("redir_req", 10);

      cyc();
      halt = 1'b1;
      cyc();
      halt = 1'b0;
      wait_valid("halt_resp", 10);
      chk("halt_pc", inst_pc, 32'h8000_0100);
      for (int i = 0; i < 20; i++) begin
         cyc();
         chk("halted_req", {31'd0, imem_req}, 32'd0);
         chk("halted_valid", {31'd0, inst_valid}, 32'd0);
      end

      rst     = 1'b1;
      lat_cfg = 0;
      cyc();
      cyc();
      rst      = 1'b0;
      imem_gnt = 1'b0;
      cyc();
      chk("rs_req", {31'd0, imem_req}, 32'd1);
      chk("rs_addr", imem_addr, 32'h8000_0000);
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFE;
      cyc();
      redirect_valid = 1'b0;
      chk("top_addr", imem_addr, 32'hFFFF_FFFC);
      imem_gnt = 1'b1;
      wait_valid("top_resp", 10);
      chk("top_pc", inst_pc, 32'hFFFF_FFFC);
      lat_cfg = 3;
      cyc();
      chk("wrap_req", {31'd0, imem_req}, 32'd1);
      chk("wrap_addr", imem_addr, 32'h0000_0000);
      cyc();
      chk("wrap_wait", {31'd0, imem_req}, 32'd0);
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      cyc();
      chk("late_req", {31'd0, imem_req}, 32'd1);
      chk("late_addr", imem_addr, 32'h8000_0000);
      chk("late_valid", {31'd0, inst_valid}, 32'd0);
      wait_valid("late_resp", 12);
      chk("late_pc", inst_pc, 32'h8000_0000);

      for (int seg = 0; seg < 6; seg++) begin
         rnd = 1'b0;
         rst = 1'b1;
         cyc();
         cyc();
         rst       = 1'b0;
         gnt_pct   = 30 + seg * 12;
         rdy_pct   = 90 - seg * 12;
         redir_pct = (seg % 3) * 6 + 2;
         halt_pm   = (seg >= 4) ? 4 : 0;
         rnd       = 1'b1;
         repeat (500) cyc();
      end
      rnd = 1'b0;
      rst = 1'b0;
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
